// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: execution sequencer for the 4-bit CPU.
// Issues a registered one-clk cpu_en pulse per instruction in free-run
// (divided rate), single-step or halt mode, and counts issued pulses.
// Optional breakpoint on the CPU fetch address: define BREAKPOINT_EN.
module cpu_step_ctrl #(
  parameter int DIV_WIDTH  = 24,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_req,
  input  logic                  step_req,
  input  logic                  halt_req,
  input  logic [DIV_WIDTH-1:0]  div_sel,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  input  logic                  bp_valid,
  output logic                  cpu_en,
  output logic                  running,
  output logic                  bp_hit,
  output logic [CNT_WIDTH-1:0]  instr_cnt
);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;

  state_t               state, state_nx;
  logic                 run_q, step_q, halt_q, armed;
  logic                 rise_run, rise_step, rise_halt;
  logic [DIV_WIDTH-1:0] div_cnt, div_nx;
  logic                 en_nx, tick, bp_match;

  // Request edge registers. 'armed' blocks edges on the first clock after
  // reset so a button held through reset does not count as a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      step_q <= 1'b0;
      halt_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      run_q  <= run_req;
      step_q <= step_req;
      halt_q <= halt_req;
      armed  <= 1'b1;
    end
  end

  assign rise_run  = armed & run_req  & ~run_q;
  assign rise_step = armed & step_req & ~step_q;
  assign rise_halt = armed & halt_req & ~halt_q;

  // '>=' so that shrinking div_sel below the current count ticks right away.
  assign tick    = (div_cnt >= div_sel);
  assign running = (state == S_RUN);

  // Next state, divider and pulse request; halt > step > run.
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    en_nx    = 1'b0;
    unique case (state)
      S_HALT: begin
        if (!rise_halt) begin
          if (rise_step) begin
            state_nx = S_STEP;
          end else if (rise_run) begin
            state_nx = S_RUN;
            div_nx   = '0;
          end
        end
      end
      S_STEP: begin
        en_nx    = 1'b1;
        state_nx = S_HALT;
      end
      S_RUN: begin
        if (rise_halt || rise_step) begin
          state_nx = S_HALT;
        end else if (tick) begin
          div_nx = '0;
          if (bp_match) state_nx = S_HALT;
          else          en_nx    = 1'b1;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      default: state_nx = S_HALT;
    endcase
  end

  // State, divider, registered pulse and pulse counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HALT;
      div_cnt   <= '0;
      cpu_en    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      cpu_en  <= en_nx;
      if (cpu_en) instr_cnt <= instr_cnt + 1'b1;
    end
  end

`ifdef BREAKPOINT_EN
  logic first_tick, run_entry, step_entry, bp_set;

  assign run_entry  = (state == S_HALT) & ~rise_halt & ~rise_step & rise_run;
  assign step_entry = (state == S_HALT) & ~rise_halt & rise_step;
  assign bp_set     = (state == S_RUN) & ~rise_halt & ~rise_step & tick & bp_match;
  // The first tick after entering RUN is never compared, so resuming from a
  // breakpoint executes the instruction it stopped on.
  assign bp_match   = bp_valid & (pc == bp_addr) & ~first_tick;

  // First-tick mask and sticky breakpoint flag (halt request leaves it alone).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_tick <= 1'b0;
      bp_hit     <= 1'b0;
    end else begin
      if (run_entry)                    first_tick <= 1'b1;
      else if ((state == S_RUN) && tick) first_tick <= 1'b0;
      if (bp_set)                        bp_hit <= 1'b1;
      else if (run_entry || step_entry)  bp_hit <= 1'b0;
    end
  end
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = &{1'b0, pc, bp_addr, bp_valid};
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: vector table, corner sequences and randomized run
// against a cycle-stamp reference model of the step controller.
module tb_cpu_step_ctrl;

`ifdef BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  logic        clk = 1'b0, rst_n;
  logic        run_req, step_req, halt_req, bp_valid;
  logic [23:0] div_sel;
  logic [3:0]  pc, bp_addr;
  logic        cpu_en, running, bp_hit;
  logic [15:0] instr_cnt;

  int vecs = 0;
  int errs = 0;

  cpu_step_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .div_sel(div_sel), .pc(pc), .bp_addr(bp_addr),
    .bp_valid(bp_valid), .cpu_en(cpu_en), .running(running), .bp_hit(bp_hit),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=HALT 1=RUN 2=STEP; RUN timing from cycle stamps.
  int          m_mode;
  longint      cyc, origin;
  bit          m_en, m_first, m_bp, m_primed, p_run, p_step, p_halt, pc_pend;
  logic [15:0] m_cnt;

  function automatic void model_reset();
    m_mode = 0; cyc = 0; origin = 0; m_en = 0; m_first = 0; m_bp = 0;
    m_primed = 0; p_run = 0; p_step = 0; p_halt = 0; pc_pend = 0; m_cnt = '0;
  endfunction

  function automatic void model_update();
    bit rr, rs, rh, ne;
    rr = run_req  && !p_run  && m_primed;
    rs = step_req && !p_step && m_primed;
    rh = halt_req && !p_halt && m_primed;
    ne = 0;
    if (m_mode == 0) begin
      if (!rh && rs)      begin m_mode = 2; m_bp = 0; end
      else if (!rh && rr) begin m_mode = 1; m_bp = 0; m_first = 1; origin = cyc + 1; end
    end else if (m_mode == 2) begin
      ne = 1; m_mode = 0;
    end else begin
      if (rh || rs) m_mode = 0;
      else if ((cyc - origin) >= longint'(div_sel)) begin
        origin = cyc + 1;
        if (BP_ON && bp_valid && pc == bp_addr && !m_first) begin
          m_mode = 0; m_bp = 1;
        end else ne = 1;
        m_first = 0;
      end
    end
    if (m_en) begin m_cnt = m_cnt + 16'd1; pc_pend = 1; end
    m_en = ne;
    p_run = run_req; p_step = step_req; p_halt = halt_req;
    m_primed = 1; cyc++;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic model_cmp(input string nm, input int idx);
    chk(nm, idx, {13'd0, cpu_en, running, bp_hit, instr_cnt},
        {13'd0, m_en, (m_mode == 1), m_bp, m_cnt});
  endtask

  // One clock: model advances on the edge, CPU pc moves, outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (pc_pend) pc = pc + 4'd1;
    pc_pend = 0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; pc = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit run, step, halt;
    logic [23:0] div;
    bit en, rn;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[26];

  task automatic setv(input int i, input bit r, input bit s, input bit h, input int d,
                      input bit e, input bit n, input int c);
    tbl[i] = '{r, s, h, 24'(d), e, n, 16'(c)};
  endtask

  int npulse;

  initial begin
    rst_n = 1'b0; run_req = 1'b1; step_req = 0; halt_req = 0;
    div_sel = 24'd3; pc = '0; bp_addr = '0; bp_valid = 0;

    // run, step, halt, div_sel -> cpu_en, running, instr_cnt
    setv(0, 1,0,0,3, 0,0,0); setv(1, 1,0,0,3, 0,0,0); setv(2, 0,0,0,3, 0,0,0);
    setv(3, 0,1,0,3, 0,0,0); setv(4, 0,1,0,3, 1,0,0); setv(5, 0,1,0,3, 0,0,1);
    setv(6, 0,1,0,3, 0,0,1); setv(7, 0,0,0,3, 0,0,1); setv(8, 1,0,0,3, 0,1,1);
    setv(9, 1,0,0,3, 0,1,1); setv(10,1,0,0,3, 0,1,1); setv(11,1,0,0,3, 0,1,1);
    setv(12,1,0,0,3, 1,1,1); setv(13,1,0,0,3, 0,1,2); setv(14,1,0,0,3, 0,1,2);
    setv(15,1,0,0,3, 0,1,2); setv(16,1,0,0,3, 1,1,2); setv(17,1,0,0,3, 0,1,3);
    setv(18,1,0,1,3, 0,0,3); setv(19,1,0,1,3, 0,0,3); setv(20,0,0,0,0, 0,0,3);
    setv(21,1,0,0,0, 0,1,3); setv(22,1,0,0,0, 1,1,3); setv(23,1,0,0,0, 1,1,4);
    setv(24,1,1,0,0, 0,0,5); setv(25,0,0,0,0, 0,0,5);

    // Reset state with run_req held high, then the vector table.
    model_reset();
    #12;
    chk("reset", 0, {28'd0, cpu_en, running, bp_hit, instr_cnt != 0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      run_req = tbl[i].run; step_req = tbl[i].step; halt_req = tbl[i].halt;
      div_sel = tbl[i].div;
      tick();
      chk("tbl", i, {14'd0, cpu_en, running, instr_cnt}, {14'd0, tbl[i].en, tbl[i].rn, tbl[i].cnt});
    end

    // Step held high for 20+ clocks gives exactly one pulse.
    run_req = 0; step_req = 0; halt_req = 0; reset_dut(); tick();
    step_req = 1; npulse = 0;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (cpu_en) npulse++;
      if (running) npulse += 100;
    end
    chk("step_held_pulses", 0, npulse, 1);
    chk("step_held_cnt", 0, {16'd0, instr_cnt}, 32'd1);
    step_req = 0;

    // Async reset mid-RUN between ticks.
    reset_dut(); div_sel = 24'd5; tick(); run_req = 1;
    for (int k = 0; k < 16; k++) tick();
    model_cmp("pre_rst", 0);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst", 0, {15'd0, cpu_en, running, instr_cnt}, 32'd0);
    model_reset(); pc = '0;
    @(negedge clk); rst_n = 1'b1; run_req = 0;

    // div_sel=0: back-to-back pulses and counter wrap.
    div_sel = 24'd0; tick(); run_req = 1;
    for (int k = 0; k < 70000 && m_cnt != 16'hFFFE; k++) tick();
    chk("wrap_fffe", 0, {16'd0, instr_cnt}, 32'h0000_FFFE);
    tick(); chk("wrap_ffff", 0, {15'd0, cpu_en, instr_cnt}, 32'h0001_FFFF);
    tick(); chk("wrap_zero", 0, {15'd0, cpu_en, instr_cnt}, 32'h0001_0000);
    run_req = 0;

`ifdef BREAKPOINT_EN
    // Breakpoint at pc 5, then resume executes pc 5.
    reset_dut(); bp_addr = 4'h5; bp_valid = 1; div_sel = 24'd1; tick(); run_req = 1;
    for (int k = 0; k < 40; k++) begin
      tick(); model_cmp("bp_run", k);
      if (k > 0 && m_mode == 0) break;
    end
    chk("bp_halt", 0, {10'd0, running, bp_hit, pc, instr_cnt}, {10'd0, 1'b0, 1'b1, 4'h5, 16'd5});
    run_req = 0; tick(); run_req = 1;
    tick(); chk("bp_clear", 0, {30'd0, running, bp_hit}, 32'd2);
    for (int k = 0; k < 4; k++) tick();
    chk("bp_resume", 0, {12'd0, pc, instr_cnt}, {12'd0, 4'h6, 16'd6});
    run_req = 0; halt_req = 1; tick(); halt_req = 0;
`endif

    // Randomized stimulus against the model.
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0)  run_req  = ~run_req;
      if ($urandom_range(0, 11) == 0) step_req = ~step_req;
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 39) == 0) div_sel  = 24'($urandom_range(0, 5));
      if ($urandom_range(0, 29) == 0) bp_valid = ~bp_valid;
      if ($urandom_range(0, 59) == 0) bp_addr  = 4'($urandom_range(0, 15));
      tick();
      model_cmp("rand", i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
